// File: rtl/cellrv32_cpu_cp_sched_pkg.sv
// -----------------------------------------------------------------------------
// cellrv32_cpu_cp_sched_pkg
// Shared types and constants for the co-processor issue scheduler.
//   cp_sched_state_t          : scheduler FSM states (IDLE / RUN / DONE)
//   CP_SCHED_TMO_LOG_DEFAULT  : default log2 of the co-processor timeout
//   cp_slot_legal()           : is a slot select implemented in this build?
// -----------------------------------------------------------------------------
package cellrv32_cpu_cp_sched_pkg;

  typedef enum logic [1:0] {
    CP_S_IDLE,
    CP_S_RUN,
    CP_S_DONE
  } cp_sched_state_t;

  localparam int CP_SCHED_TMO_LOG_DEFAULT = 7;

  // A slot is legal when it exists (below num_cp) and is enabled in cp_en.
  function automatic logic cp_slot_legal(input logic [2:0] sel,
                                         input int         num_cp,
                                         input logic [7:0] cp_en);
    return (int'(sel) < num_cp) && cp_en[sel];
  endfunction

endpackage

// File: rtl/cellrv32_cpu_cp_sched_if.sv
// -----------------------------------------------------------------------------
// cellrv32_cpu_cp_sched_if
// Bundles the issue-side and co-processor-side signals of the scheduler.
//   master : issuing CPU control FSM plus the cp_* units (drive req/sel/flush
//            and the per-slot valid/result lines, observe start/result/status)
//   slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface cellrv32_cpu_cp_sched_if #(
  parameter int XLEN   = 32,
  parameter int NUM_CP = 8
);

  logic                     req;
  logic [2:0]               sel;
  logic                     flush;
  logic [NUM_CP-1:0]        cp_start;
  logic [NUM_CP-1:0]        cp_valid;
  logic [NUM_CP*XLEN-1:0]   cp_res;
  logic [XLEN-1:0]          res;
  logic                     done;
  logic                     exc;
  logic                     busy;

  modport master (
    output req, sel, flush, cp_valid, cp_res,
    input  cp_start, res, done, exc, busy
  );

  modport slave (
    input  req, sel, flush, cp_valid, cp_res,
    output cp_start, res, done, exc, busy
  );

endinterface

// File: rtl/cellrv32_cpu_cp_sched.sv
// -----------------------------------------------------------------------------
// cellrv32_cpu_cp_sched
// Issue scheduler for the CPU co-processor slots. Accepts one request from the
// execute stage, holds a one-hot level start on the selected slot, waits for
// that slot's valid (bounded by a timeout) and returns a registered result.
//
// Ports
//   clk_i       in   global clock, rising edge
//   rstn_i      in   asynchronous active-low reset
//   req_i       in   issue strobe, sampled in IDLE only
//   sel_i       in   target slot, sampled with req_i
//   flush_i     in   abort (trap / branch kill), level
//   cp_start_o  out  one-hot level start, only while RUN
//   cp_valid_i  in   per-slot result valid
//   cp_res_i    in   per-slot results, slot i at [i*XLEN +: XLEN]
//   res_o       out  registered result
//   done_o      out  one-cycle completion pulse
//   exc_o       out  with done_o: illegal slot or timeout
//   busy_o      out  high outside IDLE
// -----------------------------------------------------------------------------
module cellrv32_cpu_cp_sched
  import cellrv32_cpu_cp_sched_pkg::*;
#(
  parameter int         XLEN    = 32,
  parameter int         NUM_CP  = 8,
  parameter logic [7:0] CP_EN   = 8'hFF,
  parameter int         TMO_LOG = CP_SCHED_TMO_LOG_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   req_i,
  input  logic [2:0]             sel_i,
  input  logic                   flush_i,
  output logic [NUM_CP-1:0]      cp_start_o,
  input  logic [NUM_CP-1:0]      cp_valid_i,
  input  logic [NUM_CP*XLEN-1:0] cp_res_i,
  output logic [XLEN-1:0]        res_o,
  output logic                   done_o,
  output logic                   exc_o,
  output logic                   busy_o
);

  // Terminal count: reaching it in RUN without a valid is a timeout.
  localparam logic [TMO_LOG-1:0] CNT_MAX = '1;

  cp_sched_state_t    state_q, state_d;
  logic [2:0]         sel_q,   sel_d;
  logic [TMO_LOG-1:0] cnt_q,   cnt_d;
  logic [TMO_LOG-1:0] cnt_inc;
  logic [XLEN-1:0]    res_q,   res_d;
  logic               exc_q,   exc_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= CP_S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TMO_LOG'(1);

  // ---------------------------------------------------------------------------
  // Next state. Priority inside RUN: flush > valid > timeout, so a valid that
  // lands on the final timeout cycle still completes without an exception.
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets its hold value first; a path that
  // forgot one would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    exc_d   = exc_q;

    unique case (state_q)
      CP_S_IDLE: begin
        exc_d = 1'b0;
        cnt_d = '0;
        // A same-cycle flush blocks acceptance of the request.
        if (req_i && !flush_i) begin
          if (cp_slot_legal(sel_i, NUM_CP, CP_EN)) begin
            sel_d   = sel_i;
            state_d = CP_S_RUN;
          end else begin
            // Illegal slot: report immediately, never raise a start.
            res_d   = '0;
            exc_d   = 1'b1;
            state_d = CP_S_DONE;
          end
        end
      end

      CP_S_RUN: begin
        cnt_d = cnt_inc;
        if (flush_i) begin
          cnt_d   = '0;
          state_d = CP_S_IDLE;
        end else if (cp_valid_i[sel_q]) begin
          // Indexed part-select on the latched slot; other slots never reach res.
          res_d   = cp_res_i[int'(sel_q)*XLEN +: XLEN];
          exc_d   = 1'b0;
          state_d = CP_S_DONE;
        end else if (cnt_inc == CNT_MAX) begin
          res_d   = '0;
          exc_d   = 1'b1;
          state_d = CP_S_DONE;
        end
      end

      CP_S_DONE: begin
        // done_o is decoded from this state, so it lasts exactly one cycle;
        // a flush here lands in IDLE just the same.
        exc_d   = 1'b0;
        cnt_d   = '0;
        state_d = CP_S_IDLE;
      end

      default: begin
        exc_d   = 1'b0;
        cnt_d   = '0;
        state_d = CP_S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, all decoded from flops so reset clears them asynchronously.
  // ---------------------------------------------------------------------------
  always_comb begin
    cp_start_o = '0;
    if (state_q == CP_S_RUN) begin
      cp_start_o = NUM_CP'(1) << sel_q;
    end
  end

  assign res_o  = res_q;
  assign done_o = (state_q == CP_S_DONE);
  assign exc_o  = (state_q == CP_S_DONE) && exc_q;
  assign busy_o = (state_q != CP_S_IDLE);

endmodule
